// File: rtl/ifu_fetch_unit.sv
// ifu_fetch_unit
// Instruction-fetch stage. Issues word reads to the instruction memory with at
// most one request outstanding, decodes the immediate of each returned word
// and hands {inst, pc, imm, exception, mcause} to decode over valid/ready.
// Owns the fetch PC: sequential +4 on each transfer, or redirect on i_flush.
//
// Ports:
//   i_clock, i_reset              clock, synchronous active-high reset
//   o_mem_req_valid/i_mem_req_ready/o_mem_addr   fetch request channel
//   i_mem_rsp_valid/i_mem_rdata/i_mem_rsp_err     fetch response (always accepted)
//   o_valid/i_ready/i_stall       decode handshake (transfer = valid&ready&!stall&!flush)
//   i_flush/i_flush_pc            redirect, kills held and in-flight fetch
//   o_inst/o_pc/o_imm             decode payload
//   o_exception/o_mcause          fetch exception (0 = misaligned, 1 = access fault)
module ifu_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        i_clock,
    input  logic        i_reset,
    output logic        o_mem_req_valid,
    input  logic        i_mem_req_ready,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_rsp_valid,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_rsp_err,
    output logic        o_valid,
    input  logic        i_ready,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_flush_pc,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_imm,
    output logic        o_exception,
    output logic [3:0]  o_mcause
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        req_valid_q, req_valid_d;
    logic        drop_q, drop_d;
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] opc_q, opc_d;
    logic [31:0] imm_q, imm_d;
    logic        exc_q, exc_d;
    logic [3:0]  mcause_q, mcause_d;

    logic transfer;
    logic accept;

    function automatic logic [31:0] immgen(input logic [31:0] inst);
        logic [31:0] imm;
        imm = '0;
        case (inst[6:2])
            5'b00100, 5'b00000, 5'b11001, 5'b11100:
                imm = {{20{inst[31]}}, inst[31:20]};
            5'b01000:
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            5'b11000:
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            5'b01101, 5'b00101:
                imm = {inst[31:12], 12'b0};
            5'b11011:
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm = '0;
        endcase
        return imm;
    endfunction

    assign transfer = valid_q & i_ready & ~i_stall & ~i_flush;
    assign accept   = req_valid_q & i_mem_req_ready;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            addr_q      <= '0;
            req_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            valid_q     <= 1'b0;
            inst_q      <= NOP_INST;
            opc_q       <= '0;
            imm_q       <= '0;
            exc_q       <= 1'b0;
            mcause_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            req_valid_q <= req_valid_d;
            drop_q      <= drop_d;
            valid_q     <= valid_d;
            inst_q      <= inst_d;
            opc_q       <= opc_d;
            imm_q       <= imm_d;
            exc_q       <= exc_d;
            mcause_q    <= mcause_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        req_valid_d = req_valid_q;
        drop_d      = drop_q;
        valid_d     = valid_q;
        inst_d      = inst_q;
        opc_d       = opc_q;
        imm_d       = imm_q;
        exc_d       = exc_q;
        mcause_d    = mcause_q;

        if (i_flush) begin
            valid_d = 1'b0;
            pc_d    = i_flush_pc;
            state_d = S_REQ;
            case (state_q)
                // An issued request is never withdrawn: it keeps its address
                // until accepted, and its response is then swallowed via drop.
                S_REQ: begin
                    if (req_valid_q) begin
                        drop_d = 1'b1;
                        if (accept) begin
                            req_valid_d = 1'b0;
                            state_d     = S_WAIT;
                        end
                    end
                end
                // A response arriving with the flush is discarded right here,
                // so nothing is left in flight and drop ends up clear.
                S_WAIT: begin
                    if (i_mem_rsp_valid) begin
                        drop_d = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                default: ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (req_valid_q) begin
                        if (accept) begin
                            req_valid_d = 1'b0;
                            state_d     = S_WAIT;
                        end
                    end else if (pc_q[1:0] != 2'b00) begin
                        inst_d   = NOP_INST;
                        opc_d    = pc_q;
                        imm_d    = '0;
                        exc_d    = 1'b1;
                        mcause_d = 4'd0;
                        valid_d  = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        req_valid_d = 1'b1;
                        addr_d      = pc_q;
                    end
                end
                S_WAIT: begin
                    if (i_mem_rsp_valid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            inst_d   = i_mem_rdata;
                            opc_d    = pc_q;
                            imm_d    = immgen(i_mem_rdata);
                            exc_d    = i_mem_rsp_err;
                            mcause_d = {3'b000, i_mem_rsp_err};
                            valid_d  = 1'b1;
                            state_d  = i_mem_rsp_err ? S_HALT : S_HOLD;
                        end
                    end
                end
                // The next request is raised in the transfer cycle itself so it
                // is visible on the following cycle; pc stays word aligned here.
                S_HOLD: begin
                    if (transfer) begin
                        valid_d     = 1'b0;
                        pc_d        = pc_q + 32'd4;
                        addr_d      = pc_q + 32'd4;
                        req_valid_d = 1'b1;
                        state_d     = S_REQ;
                    end
                end
                default: begin
                    if (transfer) begin
                        valid_d = 1'b0;
                    end
                end
            endcase
        end
    end

    assign o_mem_req_valid = req_valid_q;
    assign o_mem_addr      = addr_q;
    assign o_valid         = valid_q;
    assign o_inst          = inst_q;
    assign o_pc            = opc_q;
    assign o_imm           = imm_q;
    assign o_exception     = exc_q;
    assign o_mcause        = mcause_q;

`ifndef SYNTHESIS
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            assert (!(i_mem_rsp_valid && state_q != S_WAIT))
                else $error("ifu_fetch_unit: memory response while no request outstanding");
            assert (!(req_valid_q && state_q == S_WAIT))
                else $error("ifu_fetch_unit: second request while one is outstanding");
        end
    end
`endif

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// tb_ifu_fetch_unit
// Directed bench for ifu_fetch_unit. Inputs are driven and outputs sampled on
// the falling clock edge; every expected value is a hand-computed constant.
module tb_ifu_fetch_unit;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready;
    logic [31:0] o_mem_addr;
    logic        i_mem_rsp_valid;
    logic [31:0] i_mem_rdata;
    logic        i_mem_rsp_err;
    logic        o_valid;
    logic        i_ready;
    logic        i_stall;
    logic        i_flush;
    logic [31:0] i_flush_pc;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic [31:0] o_imm;
    logic        o_exception;
    logic [3:0]  o_mcause;

    int n_checks = 0;
    int n_fail   = 0;

    ifu_fetch_unit #(
        .RESET_PC (32'h8000_0000),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .o_mem_req_valid (o_mem_req_valid),
        .i_mem_req_ready (i_mem_req_ready),
        .o_mem_addr      (o_mem_addr),
        .i_mem_rsp_valid (i_mem_rsp_valid),
        .i_mem_rdata     (i_mem_rdata),
        .i_mem_rsp_err   (i_mem_rsp_err),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .i_stall         (i_stall),
        .i_flush         (i_flush),
        .i_flush_pc      (i_flush_pc),
        .o_inst          (o_inst),
        .o_pc            (o_pc),
        .o_imm           (o_imm),
        .o_exception     (o_exception),
        .o_mcause        (o_mcause)
    );

    always #5 i_clock = ~i_clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clock);
        @(negedge i_clock);
    endtask

    // Wait (bounded) for a fetch request and check its address.
    task automatic wait_req(input logic [31:0] exp_addr);
        int unsigned n;
        n = 0;
        while (!o_mem_req_valid && n < 20) begin
            step();
            n++;
        end
        check_eq("req_seen", {31'b0, o_mem_req_valid}, 32'd1);
        check_eq("req_addr", o_mem_addr, exp_addr);
    endtask

    // Accept one request, respond one cycle later, check the presented payload.
    task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] rdata,
                         input logic err, input logic [31:0] exp_imm);
        wait_req(exp_addr);
        i_mem_req_ready = 1'b1;
        step();
        i_mem_req_ready = 1'b0;
        check_eq("req_dropped_after_accept", {31'b0, o_mem_req_valid}, 32'd0);
        i_mem_rsp_valid = 1'b1;
        i_mem_rdata     = rdata;
        i_mem_rsp_err   = err;
        step();
        i_mem_rsp_valid = 1'b0;
        i_mem_rsp_err   = 1'b0;
        check_eq("valid", {31'b0, o_valid}, 32'd1);
        check_eq("pc", o_pc, exp_addr);
        check_eq("inst", o_inst, rdata);
        check_eq("imm", o_imm, exp_imm);
        check_eq("exc", {31'b0, o_exception}, {31'b0, err});
        check_eq("mcause", {28'b0, o_mcause}, {31'b0, err});
    endtask

    task automatic take();
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        check_eq("valid_after_take", {31'b0, o_valid}, 32'd0);
    endtask

    task automatic flush_to(input logic [31:0] target);
        i_flush    = 1'b1;
        i_flush_pc = target;
        step();
        i_flush    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_reset = 1'b1;
        i_mem_req_ready = 1'b0;
        i_mem_rsp_valid = 1'b0;
        i_mem_rdata = '0;
        i_mem_rsp_err = 1'b0;
        i_ready = 1'b0;
        i_stall = 1'b0;
        i_flush = 1'b0;
        i_flush_pc = '0;
        step();
        step();

        // Reset state
        check_eq("rst_valid", {31'b0, o_valid}, 32'd0);
        check_eq("rst_req", {31'b0, o_mem_req_valid}, 32'd0);
        check_eq("rst_inst", o_inst, 32'h0000_0013);
        check_eq("rst_pc", o_pc, 32'd0);
        check_eq("rst_imm", o_imm, 32'd0);
        check_eq("rst_exc", {31'b0, o_exception}, 32'd0);
        check_eq("rst_mcause", {28'b0, o_mcause}, 32'd0);

        // First request one cycle after reset release
        i_reset = 1'b0;
        step();
        check_eq("first_req", {31'b0, o_mem_req_valid}, 32'd1);
        check_eq("first_addr", o_mem_addr, 32'h8000_0000);

        // addi x1, x0, 5
        fetch(32'h8000_0000, 32'h0050_0093, 1'b0, 32'd5);

        // Backpressure: i_ready low, then stalled with i_ready high
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("hold_valid", {31'b0, o_valid}, 32'd1);
            check_eq("hold_inst", o_inst, 32'h0050_0093);
            check_eq("hold_noreq", {31'b0, o_mem_req_valid}, 32'd0);
        end
        i_ready = 1'b1;
        i_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("stall_valid", {31'b0, o_valid}, 32'd1);
            check_eq("stall_pc", o_pc, 32'h8000_0000);
            check_eq("stall_noreq", {31'b0, o_mem_req_valid}, 32'd0);
        end
        i_stall = 1'b0;
        step();
        i_ready = 1'b0;
        check_eq("xfer_valid", {31'b0, o_valid}, 32'd0);
        check_eq("xfer_next_req", {31'b0, o_mem_req_valid}, 32'd1);
        check_eq("xfer_next_addr", o_mem_addr, 32'h8000_0004);

        // Immediate decode
        fetch(32'h8000_0004, 32'hFE00_0EE3, 1'b0, 32'hFFFF_FFFC); // beq, imm[11]=1
        take();
        fetch(32'h8000_0008, 32'hFE00_0E63, 1'b0, 32'hFFFF_F7FC); // beq, imm[11]=0
        take();
        fetch(32'h8000_000C, 32'h1234_50B7, 1'b0, 32'h1234_5000); // lui
        take();
        fetch(32'h8000_0010, 32'h8000_00EF, 1'b0, 32'hFFF0_0000); // jal
        take();
        fetch(32'h8000_0014, 32'hFE11_2E23, 1'b0, 32'hFFFF_FFFC); // sw

        // Flush while holding a payload; flush beats the would-be transfer
        i_ready = 1'b1;
        flush_to(32'h8000_0040);
        i_ready = 1'b0;
        check_eq("hflush_valid", {31'b0, o_valid}, 32'd0);
        fetch(32'h8000_0040, 32'hFFF0_0093, 1'b0, 32'hFFFF_FFFF); // addi -1
        take();

        // Flush while waiting for a response; stale word arrives 3 cycles later
        wait_req(32'h8000_0044);
        i_mem_req_ready = 1'b1;
        step();
        i_mem_req_ready = 1'b0;
        flush_to(32'h8000_1000);
        step();
        step();
        check_eq("wflush_noreq", {31'b0, o_mem_req_valid}, 32'd0);
        i_mem_rsp_valid = 1'b1;
        i_mem_rdata = 32'hDEAD_BEEF;
        step();
        i_mem_rsp_valid = 1'b0;
        check_eq("stale_valid", {31'b0, o_valid}, 32'd0);
        check_eq("stale_inst", o_inst, 32'hFFF0_0093);
        fetch(32'h8000_1000, 32'h0050_0093, 1'b0, 32'd5);
        take();

        // Flush while a request is pending but not yet accepted
        check_eq("pend_req", {31'b0, o_mem_req_valid}, 32'd1);
        flush_to(32'h8000_2000);
        check_eq("pend_req_kept", {31'b0, o_mem_req_valid}, 32'd1);
        check_eq("pend_addr_kept", o_mem_addr, 32'h8000_1004);
        i_mem_req_ready = 1'b1;
        step();
        i_mem_req_ready = 1'b0;
        i_mem_rsp_valid = 1'b1;
        i_mem_rdata = 32'h1234_5678;
        step();
        i_mem_rsp_valid = 1'b0;
        check_eq("pend_stale_valid", {31'b0, o_valid}, 32'd0);

        // Access fault halts fetch until the next flush
        fetch(32'h8000_2000, 32'h0000_0000, 1'b1, 32'd0);
        take();
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("halt_noreq", {31'b0, o_mem_req_valid}, 32'd0);
        end
        flush_to(32'h8000_0100);
        fetch(32'h8000_0100, 32'h1234_50B7, 1'b0, 32'h1234_5000);

        // Flush to a misaligned target from HOLD
        flush_to(32'h8000_0102);
        check_eq("mis_valid0", {31'b0, o_valid}, 32'd0);
        check_eq("mis_noreq0", {31'b0, o_mem_req_valid}, 32'd0);
        step();
        check_eq("mis_valid", {31'b0, o_valid}, 32'd1);
        check_eq("mis_inst", o_inst, 32'h0000_0013);
        check_eq("mis_pc", o_pc, 32'h8000_0102);
        check_eq("mis_imm", o_imm, 32'd0);
        check_eq("mis_exc", {31'b0, o_exception}, 32'd1);
        check_eq("mis_mcause", {28'b0, o_mcause}, 32'd0);
        check_eq("mis_noreq", {31'b0, o_mem_req_valid}, 32'd0);
        take();
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("mis_halt_noreq", {31'b0, o_mem_req_valid}, 32'd0);
            check_eq("mis_halt_valid", {31'b0, o_valid}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
